// File: rtl/calc_scroll_display.sv
// calc_scroll_display
//   Multiplexed seven-segment front end with two personalities:
//   a scrolling ASCII message (mode=0) and a signed add/subtract
//   calculator (mode=1). The calculator result is converted to BCD
//   with a sequential shift-add-3 engine taking WIDTH cycles.
//
// Ports
//   clock    : system clock, rising edge
//   reset    : synchronous, active-high
//   mode     : 0 = scroll message, 1 = calculator
//   op       : 0 = add, 1 = subtract (sampled on the equal rising edge)
//   equal    : level input, rising edge triggers an operation
//   operand  : signed two's-complement operand, WIDTH bits
//   anode    : active-low digit enables, anode[0] = rightmost digit
//   SSD      : active-low segments, bit6 = a ... bit0 = g
//   LED      : signed overflow of the last operation
module calc_scroll_display #(
  parameter int                   DIGITS     = 4,
  parameter int                   WIDTH      = 8,
  parameter int                   MSG_LEN    = 12,
  parameter logic [8*MSG_LEN-1:0] MSG        = "123456789   ",
  parameter int                   SCROLL_DIV = 100000000,
  parameter int                   MUX_DIV    = 200000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic              op,
  input  logic              equal,
  input  logic [WIDTH-1:0]  operand,
  output logic [DIGITS-1:0] anode,
  output logic [6:0]        SSD,
  output logic              LED
);

  localparam int BCD_W = 4 * (DIGITS - 1);
  localparam int SC_W  = $clog2(SCROLL_DIV + 1);
  localparam int MX_W  = $clog2(MUX_DIV + 1);
  localparam int POS_W = $clog2(MSG_LEN + 1);
  localparam int DIG_W = $clog2(DIGITS);
  localparam int BIT_W = $clog2(WIDTH + 1);

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(SCROLL_DIV - 1);
  localparam logic [MX_W-1:0]  MX_LAST  = MX_W'(MUX_DIV - 1);
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(MSG_LEN - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(DIGITS - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);

  localparam logic [6:0] BLANK = 7'b1111111;
  localparam logic [6:0] MINUS = 7'b1111110;

  typedef enum logic [1:0] {IDLE, SCROLL, CALC, CONV} state_t;

  state_t                    state_q, state_d;
  logic [POS_W-1:0]          pos_q, pos_d;
  logic [SC_W-1:0]           scnt_q, scnt_d;
  logic [MX_W-1:0]           mcnt_q, mcnt_d;
  logic [DIG_W-1:0]          dig_q, dig_d;
  logic                      eq_prev_q;
  logic signed [WIDTH-1:0]   acc_q, acc_d;
  logic                      led_q, led_d;
  logic [BCD_W-1:0]          bcd_q, bcd_d;
  logic [WIDTH-1:0]          shift_q, shift_d;
  logic [BIT_W-1:0]          bitc_q, bitc_d;
  logic [BCD_W-1:0]          disp_bcd_q, disp_bcd_d;
  logic                      disp_neg_q, disp_neg_d;
  logic [DIGITS-1:0]         anode_q, anode_d;
  logic [6:0]                ssd_q, ssd_d;

  logic signed [WIDTH-1:0]   operand_s;
  logic signed [WIDTH-1:0]   acc_new;
  logic                      equal_rise;
  logic [BCD_W-1:0]          bcd_adj;
  logic [4*DIGITS-1:0]       disp_ext;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0000001;
      4'd1:    seg_code = 7'b1001111;
      4'd2:    seg_code = 7'b0010010;
      4'd3:    seg_code = 7'b0000110;
      4'd4:    seg_code = 7'b1001100;
      4'd5:    seg_code = 7'b0100100;
      4'd6:    seg_code = 7'b0100000;
      4'd7:    seg_code = 7'b0001111;
      4'd8:    seg_code = 7'b0000000;
      4'd9:    seg_code = 7'b0000100;
      default: seg_code = BLANK;
    endcase
  endfunction

  // ASCII '0'..'9' share their low nibble with the digit value.
  function automatic logic [6:0] char_seg(input logic [7:0] c);
    if (c >= 8'h30 && c <= 8'h39) char_seg = seg_code(c[3:0]);
    else                          char_seg = BLANK;
  endfunction

  function automatic logic [7:0] msg_char(input logic [POS_W-1:0] p, input int k);
    int idx;
    idx      = (int'(p) + DIGITS - 1 - k) % MSG_LEN;
    msg_char = MSG[8*(MSG_LEN-1-idx) +: 8];
  endfunction

  // The most negative value maps to 2^(WIDTH-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? WIDTH'(-v) : WIDTH'(v);
  endfunction

  // Subtraction flips only the operand sign bit, so a most-negative
  // subtrahend behaves as true signed subtraction.
  function automatic logic overflow(input logic signed [WIDTH-1:0] a,
                                    input logic signed [WIDTH-1:0] b,
                                    input logic signed [WIDTH-1:0] r,
                                    input logic                    sub);
    logic b_sign;
    b_sign   = sub ? ~b[WIDTH-1] : b[WIDTH-1];
    overflow = (a[WIDTH-1] == b_sign) && (r[WIDTH-1] != a[WIDTH-1]);
  endfunction

  function automatic logic [BCD_W-1:0] dd_adjust(input logic [BCD_W-1:0] b);
    dd_adjust = b;
    for (int i = 0; i < DIGITS - 1; i++) begin
      if (b[4*i +: 4] >= 4'd5) dd_adjust[4*i +: 4] = b[4*i +: 4] + 4'd3;
    end
  endfunction

  assign operand_s  = operand;
  assign acc_new    = op ? (acc_q - operand_s) : (acc_q + operand_s);
  assign equal_rise = equal & ~eq_prev_q;
  assign bcd_adj    = dd_adjust(bcd_q);
  assign disp_ext   = {4'b0000, disp_bcd_q};

  always_comb begin
    state_d    = state_q;
    pos_d      = pos_q;
    scnt_d     = scnt_q;
    mcnt_d     = mcnt_q;
    dig_d      = dig_q;
    acc_d      = acc_q;
    led_d      = led_q;
    bcd_d      = bcd_q;
    shift_d    = shift_q;
    bitc_d     = bitc_q;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    anode_d    = '1;
    ssd_d      = BLANK;

    if (mcnt_q == MX_LAST) begin
      mcnt_d = '0;
      dig_d  = (dig_q == DIG_LAST) ? '0 : dig_q + 1'b1;
    end else begin
      mcnt_d = mcnt_q + 1'b1;
    end

    case (state_q)
      IDLE, SCROLL: begin
        if (mode) begin
          state_d    = CALC;
          acc_d      = '0;
          led_d      = 1'b0;
          disp_bcd_d = '0;
          disp_neg_d = 1'b0;
        end else if (state_q == IDLE) begin
          state_d = SCROLL;
          pos_d   = '0;
          scnt_d  = '0;
        end else if (scnt_q == SC_LAST) begin
          scnt_d = '0;
          pos_d  = (pos_q == POS_LAST) ? '0 : pos_q + 1'b1;
        end else begin
          scnt_d = scnt_q + 1'b1;
        end
      end
      CALC, CONV: begin
        if (!mode) begin
          state_d = SCROLL;
          pos_d   = '0;
          scnt_d  = '0;
        end else if (state_q == CALC) begin
          if (equal_rise) begin
            acc_d   = acc_new;
            led_d   = overflow(acc_q, operand_s, acc_new, op);
            shift_d = magnitude(acc_new);
            bcd_d   = '0;
            bitc_d  = '0;
            state_d = CONV;
          end
        end else begin
          // One shift-add-3 step per cycle; the top adjusted bit is always
          // zero because the BCD field is sized for the full magnitude.
          bcd_d   = BCD_W'({bcd_adj, shift_q[WIDTH-1]});
          shift_d = {shift_q[WIDTH-2:0], 1'b0};
          if (bitc_q == BIT_LAST) begin
            disp_bcd_d = bcd_d;
            disp_neg_d = acc_q[WIDTH-1];
            state_d    = CALC;
          end else begin
            bitc_d = bitc_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      anode_d = ~(DIGITS'(1) << dig_q);
      for (int k = 0; k < DIGITS; k++) begin
        if (dig_q == DIG_W'(k)) begin
          if (state_q == SCROLL)
            ssd_d = char_seg(msg_char(pos_q, k));
          else if (k == DIGITS - 1)
            ssd_d = disp_neg_q ? MINUS : BLANK;
          else if (k != 0 && (disp_ext >> (4 * k)) == '0)
            ssd_d = BLANK;
          else
            ssd_d = seg_code(disp_ext[4*k +: 4]);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= IDLE;
      pos_q      <= '0;
      scnt_q     <= '0;
      mcnt_q     <= '0;
      dig_q      <= '0;
      eq_prev_q  <= 1'b0;
      acc_q      <= '0;
      led_q      <= 1'b0;
      bcd_q      <= '0;
      shift_q    <= '0;
      bitc_q     <= '0;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      anode_q    <= '1;
      ssd_q      <= BLANK;
    end else begin
      state_q    <= state_d;
      pos_q      <= pos_d;
      scnt_q     <= scnt_d;
      mcnt_q     <= mcnt_d;
      dig_q      <= dig_d;
      eq_prev_q  <= equal;
      acc_q      <= acc_d;
      led_q      <= led_d;
      bcd_q      <= bcd_d;
      shift_q    <= shift_d;
      bitc_q     <= bitc_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      anode_q    <= anode_d;
      ssd_q      <= ssd_d;
    end
  end

  assign anode = anode_q;
  assign SSD   = ssd_q;
  assign LED   = led_q;

endmodule

// File: tb/tb_calc_scroll_display.sv
// Directed bench for calc_scroll_display with fast dividers
// (SCROLL_DIV=4, MUX_DIV=2) and default DIGITS/WIDTH/MSG.
module tb_calc_scroll_display;

  logic       clk = 1'b0;
  logic       reset;
  logic       mode;
  logic       op;
  logic       equal;
  logic [7:0] operand;
  logic [3:0] anode;
  logic [6:0] SSD;
  logic       LED;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b0000001, S1 = 7'b1001111, S2 = 7'b0010010,
                         S3 = 7'b0000110, S4 = 7'b1001100, S5 = 7'b0100100,
                         S6 = 7'b0100000, S7 = 7'b0001111, S8 = 7'b0000000,
                         S9 = 7'b0000100, BL = 7'b1111111, MI = 7'b1111110;

  calc_scroll_display #(
    .DIGITS(4), .WIDTH(8), .MSG_LEN(12), .MSG("123456789   "),
    .SCROLL_DIV(4), .MUX_DIV(2)
  ) dut (
    .clock(clk), .reset(reset), .mode(mode), .op(op), .equal(equal),
    .operand(operand), .anode(anode), .SSD(SSD), .LED(LED)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  function automatic logic [6:0] seg_of(input logic [7:0] c);
    case (c)
      8'h30: seg_of = S0;  8'h31: seg_of = S1;  8'h32: seg_of = S2;
      8'h33: seg_of = S3;  8'h34: seg_of = S4;  8'h35: seg_of = S5;
      8'h36: seg_of = S6;  8'h37: seg_of = S7;  8'h38: seg_of = S8;
      8'h39: seg_of = S9;
      default: seg_of = BL;
    endcase
  endfunction

  // Leftmost digit first.
  function automatic logic [27:0] d4(input logic [6:0] a, input logic [6:0] b,
                                     input logic [6:0] c, input logic [6:0] d);
    d4 = {a, b, c, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Eight consecutive samples cover every mux slot once.
  task automatic read_disp(output logic [27:0] segs, output logic onehot_ok);
    segs      = '1;
    onehot_ok = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      case (anode)
        4'b1110: segs[6:0]   = SSD;
        4'b1101: segs[13:7]  = SSD;
        4'b1011: segs[20:14] = SSD;
        4'b0111: segs[27:21] = SSD;
        default: onehot_ok = 1'b0;
      endcase
    end
  endtask

  task automatic do_op(input logic [7:0] opd, input logic o);
    @(negedge clk); operand = opd; op = o; equal = 1'b1;
    @(negedge clk); equal = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic expect_disp(input string tag, input logic [27:0] exp_segs, input logic exp_led);
    logic [27:0] segs;
    logic        oh;
    read_disp(segs, oh);
    check({tag, "_disp"}, segs, exp_segs);
    check({tag, "_led"}, LED, exp_led);
    check({tag, "_onehot"}, oh, 1'b1);
  endtask

  initial begin
    logic [95:0] msg_s;
    logic [3:0]  exp_an;
    logic [6:0]  exp_ssd;
    logic [27:0] segs;
    logic        oh;
    int          dg, ps, ix;

    msg_s   = "123456789   ";
    reset   = 1'b1;
    mode    = 1'b0;
    op      = 1'b0;
    equal   = 1'b0;
    operand = 8'd0;

    repeat (3) @(posedge clk); #1;
    check("rst_anode", anode, 4'hF);
    check("rst_ssd", SSD, BL);
    check("rst_led", LED, 1'b0);

    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    check("idle_anode", anode, 4'hF);
    check("idle_ssd", SSD, BL);

    // Scroll: output after edge n shows digit n/2 at position (n-1)/4.
    for (int n = 1; n <= 56; n++) begin
      @(posedge clk); #1;
      dg      = (n / 2) % 4;
      ps      = ((n - 1) / 4) % 12;
      ix      = (ps + 3 - dg) % 12;
      exp_an  = ~(4'b0001 << dg);
      exp_ssd = seg_of(msg_s[8*(11-ix) +: 8]);
      check($sformatf("scroll_anode_%0d", n), anode, exp_an);
      check($sformatf("scroll_ssd_%0d", n), SSD, exp_ssd);
    end

    @(negedge clk); mode = 1'b1;
    repeat (3) @(negedge clk);
    expect_disp("calc_entry", d4(BL, BL, BL, S0), 1'b0);

    do_op(8'd5, 1'b0);
    expect_disp("add5", d4(BL, BL, BL, S5), 1'b0);

    // Display holds the old value while the conversion runs.
    @(negedge clk); operand = 8'd7; op = 1'b0; equal = 1'b1;
    read_disp(segs, oh);
    check("conv_hold", segs, d4(BL, BL, BL, S5));
    @(negedge clk); equal = 1'b0;
    repeat (4) @(negedge clk);
    expect_disp("add7", d4(BL, BL, S1, S2), 1'b0);

    do_op(8'd88, 1'b0);
    expect_disp("to100", d4(BL, S1, S0, S0), 1'b0);

    do_op(8'd50, 1'b0);
    expect_disp("ovf_add", d4(MI, S1, S0, S6), 1'b1);

    do_op(8'hFA, 1'b0);
    expect_disp("add_m6", d4(MI, S1, S1, S2), 1'b0);

    @(negedge clk); mode = 1'b0;
    @(negedge clk); mode = 1'b1;
    repeat (3) @(negedge clk);
    expect_disp("reenter1", d4(BL, BL, BL, S0), 1'b0);

    do_op(8'd3, 1'b1);
    expect_disp("sub3", d4(MI, BL, BL, S3), 1'b0);

    @(negedge clk); mode = 1'b0;
    @(negedge clk); mode = 1'b1;
    repeat (3) @(negedge clk);
    expect_disp("reenter2", d4(BL, BL, BL, S0), 1'b0);

    do_op(8'h80, 1'b1);
    expect_disp("sub_m128", d4(MI, S1, S2, S8), 1'b1);

    do_op(8'd1, 1'b1);
    expect_disp("sub_wrap", d4(BL, S1, S2, S7), 1'b1);

    // Abort a conversion by leaving calculator mode.
    @(negedge clk); operand = 8'd1; op = 1'b0; equal = 1'b1;
    @(negedge clk); equal = 1'b0;
    @(negedge clk);
    @(negedge clk); mode = 1'b0;
    @(posedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      case (anode)
        4'b1110: exp_ssd = S4;
        4'b1101: exp_ssd = S3;
        4'b1011: exp_ssd = S2;
        4'b0111: exp_ssd = S1;
        default: exp_ssd = 7'bxxxxxxx;
      endcase
      check($sformatf("abort_scroll_%0d", i), SSD, exp_ssd);
    end
    @(negedge clk); mode = 1'b1;
    repeat (3) @(negedge clk);
    expect_disp("abort_return", d4(BL, BL, BL, S0), 1'b0);

    // Equal held high across reset release must not trigger.
    @(negedge clk); operand = 8'd9; op = 1'b0; equal = 1'b1; reset = 1'b1;
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    check("rst2_anode", anode, 4'hF);
    check("rst2_ssd", SSD, BL);
    check("rst2_led", LED, 1'b0);
    @(negedge clk); reset = 1'b0;
    repeat (20) @(negedge clk);
    expect_disp("eq_held", d4(BL, BL, BL, S0), 1'b0);
    @(negedge clk); equal = 1'b0;
    do_op(8'd9, 1'b0);
    expect_disp("add9", d4(BL, BL, BL, S9), 1'b0);

    // Second rising edge during the conversion is ignored.
    @(negedge clk); operand = 8'd9; op = 1'b0; equal = 1'b1;
    @(negedge clk); equal = 1'b0;
    @(negedge clk); equal = 1'b1;
    @(negedge clk); equal = 1'b0;
    repeat (12) @(negedge clk);
    expect_disp("conv_ignore", d4(BL, BL, S1, S8), 1'b0);

    // Reset in the middle of a conversion discards it.
    @(negedge clk); operand = 8'd50; equal = 1'b1;
    @(negedge clk); equal = 1'b0;
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    repeat (12) @(negedge clk);
    expect_disp("rst_midconv", d4(BL, BL, BL, S0), 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
